// File: rtl/buyruk_onbellegi.sv
// Direct-mapped read-only instruction cache in front of fetch; zero-latency hits, word-serial line refill.
// Optional hit/miss counters are built only when ONBELLEK_SAYAC_EN is defined.
module buyruk_onbellegi #(
  parameter int unsigned SATIR_SAYISI    = 64,
  parameter int unsigned BLOK_KELIME     = 4,
  parameter int unsigned BASLANGIC_TEMIZ = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        getir_istek_i,
  input  logic [31:0] getir_ps_i,
  output logic        getir_gecerli_o,
  output logic [31:0] getir_buyruk_o,
  output logic        getir_bekle_o,
  input  logic        temizle_i,
  output logic        bellek_istek_o,
  output logic [31:0] bellek_adres_o,
  input  logic        bellek_istek_hazir_i,
  input  logic        bellek_yanit_gecerli_i,
  input  logic [31:0] bellek_yanit_veri_i,
  output logic [31:0] isabet_sayisi_o,
  output logic [31:0] iska_sayisi_o
);

  localparam int unsigned OB = $clog2(BLOK_KELIME);
  localparam int unsigned IB = $clog2(SATIR_SAYISI);
  localparam int unsigned EB = 32 - OB - IB - 2;
  localparam int unsigned SB = 32 - OB - 2;
  localparam int unsigned CB = OB + 1;

  typedef enum logic [1:0] {BOSTA, DOLDUR, YAZ} durum_t;

  durum_t durum, durum_sonraki;

  logic [EB-1:0]           etiket [SATIR_SAYISI];
  logic [31:0]             veri   [SATIR_SAYISI*BLOK_KELIME];
  logic [SATIR_SAYISI-1:0] gecerli;
  logic [SB-1:0]           hat;
  logic [CB-1:0]           istek_say, yanit_say;
  logic                    zehir;

  logic [OB-1:0] ps_ofs;
  logic [IB-1:0] ps_idx, hat_idx;
  logic [EB-1:0] ps_etk, hat_etk;
  logic          isabet_c, iska_c, kabul_c, son_yanit_c;
  logic          unused_ps;

  assign ps_ofs    = getir_ps_i[OB+1:2];
  assign ps_idx    = getir_ps_i[OB+IB+1:OB+2];
  assign ps_etk    = getir_ps_i[31:OB+IB+2];
  assign hat_idx   = hat[IB-1:0];
  assign hat_etk   = hat[SB-1:IB];
  assign unused_ps = ^getir_ps_i[1:0];

  // Lookup is purely combinational on the array read ports
  assign isabet_c    = (durum == BOSTA) && getir_istek_i && gecerli[ps_idx]
                       && (etiket[ps_idx] == ps_etk);
  assign iska_c      = (durum == BOSTA) && getir_istek_i && !isabet_c;
  assign kabul_c     = bellek_istek_o && bellek_istek_hazir_i;
  assign son_yanit_c = (durum == DOLDUR) && bellek_yanit_gecerli_i
                       && (yanit_say == CB'(BLOK_KELIME - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) durum <= BOSTA;
    else       durum <= durum_sonraki;
  end

  always_comb begin
    durum_sonraki   = durum;
    getir_gecerli_o = 1'b0;
    getir_buyruk_o  = '0;
    getir_bekle_o   = 1'b0;
    bellek_istek_o  = 1'b0;
    bellek_adres_o  = '0;
    case (durum)
      BOSTA: begin
        getir_gecerli_o = isabet_c;
        getir_bekle_o   = iska_c;
        if (isabet_c) getir_buyruk_o = veri[{ps_idx, ps_ofs}];
        if (iska_c)   durum_sonraki  = DOLDUR;
      end
      DOLDUR: begin
        getir_bekle_o  = 1'b1;
        bellek_istek_o = (istek_say < CB'(BLOK_KELIME));
        if (bellek_istek_o) bellek_adres_o = {hat, istek_say[OB-1:0], 2'b00};
        if (son_yanit_c)    durum_sonraki  = YAZ;
      end
      YAZ: begin
        getir_bekle_o = 1'b1;
        durum_sonraki = BOSTA;
      end
      default: durum_sonraki = BOSTA;
    endcase
  end

  // Refill bookkeeping: latched line, request/response counters, poison flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hat       <= '0;
      istek_say <= '0;
      yanit_say <= '0;
      zehir     <= 1'b0;
    end else begin
      if (iska_c) begin
        hat       <= getir_ps_i[31:OB+2];
        istek_say <= '0;
        yanit_say <= '0;
        zehir     <= temizle_i;
      end
      if (durum == DOLDUR) begin
        if (kabul_c)                istek_say <= istek_say + CB'(1);
        if (bellek_yanit_gecerli_i) yanit_say <= yanit_say + CB'(1);
      end
      if (temizle_i && (durum != BOSTA)) zehir <= 1'b1;
    end
  end

  // A flush always wins over the line commit in the same cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (BASLANGIC_TEMIZ != 0) gecerli <= '0;
    end else if (temizle_i) begin
      gecerli <= '0;
    end else if ((durum == YAZ) && !zehir) begin
      gecerli[hat_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if ((durum == DOLDUR) && bellek_yanit_gecerli_i)
      veri[{hat_idx, yanit_say[OB-1:0]}] <= bellek_yanit_veri_i;
    if (durum == YAZ)
      etiket[hat_idx] <= hat_etk;
  end

`ifdef ONBELLEK_SAYAC_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      isabet_sayisi_o <= '0;
      iska_sayisi_o   <= '0;
    end else begin
      if (isabet_c) isabet_sayisi_o <= isabet_sayisi_o + 32'd1;
      if (iska_c)   iska_sayisi_o   <= iska_sayisi_o + 32'd1;
    end
  end
`else
  assign isabet_sayisi_o = '0;
  assign iska_sayisi_o   = '0;
`endif

endmodule

// File: tb/tb_buyruk_onbellegi.sv
// Self-checking bench for buyruk_onbellegi: transaction-level cache model, in-order memory model,
// directed scenarios with literal expectations.
module tb_buyruk_onbellegi;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        getir_istek_i = 1'b0;
  logic [31:0] getir_ps_i = '0;
  logic        getir_gecerli_o;
  logic [31:0] getir_buyruk_o;
  logic        getir_bekle_o;
  logic        temizle_i = 1'b0;
  logic        bellek_istek_o;
  logic [31:0] bellek_adres_o;
  logic        bellek_istek_hazir_i = 1'b1;
  logic        bellek_yanit_gecerli_i = 1'b0;
  logic [31:0] bellek_yanit_veri_i = '0;
  logic [31:0] isabet_sayisi_o;
  logic [31:0] iska_sayisi_o;

  always #5 clk = ~clk;

  buyruk_onbellegi dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .getir_istek_i          (getir_istek_i),
    .getir_ps_i             (getir_ps_i),
    .getir_gecerli_o        (getir_gecerli_o),
    .getir_buyruk_o         (getir_buyruk_o),
    .getir_bekle_o          (getir_bekle_o),
    .temizle_i              (temizle_i),
    .bellek_istek_o         (bellek_istek_o),
    .bellek_adres_o         (bellek_adres_o),
    .bellek_istek_hazir_i   (bellek_istek_hazir_i),
    .bellek_yanit_gecerli_i (bellek_yanit_gecerli_i),
    .bellek_yanit_veri_i    (bellek_yanit_veri_i),
    .isabet_sayisi_o        (isabet_sayisi_o),
    .iska_sayisi_o          (iska_sayisi_o)
  );

  int tests = 0;
  int fails = 0;

  // Main memory contents: word at byte address a
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a >> 2) + 32'h60;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cache model: resident lines plus the progress of one outstanding refill
  bit          m_valid [64];
  logic [21:0] m_tag   [64];
  bit          m_busy, m_commit, m_poison;
  logic [31:0] m_line;
  int          m_sent, m_recv;
  int unsigned m_hits, m_miss;

  logic [31:0] rq[$];
  logic [31:0] acc[$];
  bit          nxt_v;
  logic [31:0] nxt_d;

  always @(negedge clk) begin : model
    logic [5:0]  idx;
    logic        e_hit, e_req;
    logic [31:0] e_h, e_m;
    if (rst_i) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_busy = 0; m_commit = 0; m_poison = 0; m_sent = 0; m_recv = 0;
      m_hits = 0; m_miss = 0;
      rq.delete();
      nxt_v = 0;
    end else begin
      idx   = getir_ps_i[9:4];
      e_hit = !m_busy && getir_istek_i && m_valid[idx] && (m_tag[idx] == getir_ps_i[31:10]);
      e_req = m_busy && !m_commit && (m_sent < 4);
`ifdef ONBELLEK_SAYAC_EN
      e_h = m_hits; e_m = m_miss;
`else
      e_h = 0; e_m = 0;
`endif
      chk("getir_gecerli", 32'(getir_gecerli_o), 32'(e_hit));
      chk("getir_bekle", 32'(getir_bekle_o), 32'(m_busy || (getir_istek_i && !e_hit)));
      chk("getir_buyruk", getir_buyruk_o, e_hit ? mem({getir_ps_i[31:2], 2'b00}) : 32'h0);
      chk("bellek_istek", 32'(bellek_istek_o), 32'(e_req));
      if (e_req) chk("bellek_adres", bellek_adres_o, m_line + 32'(m_sent * 4));
      chk("isabet_sayisi", isabet_sayisi_o, e_h);
      chk("iska_sayisi", iska_sayisi_o, e_m);

      // memory sees the DUT's handshake; one-cycle response latency, in order
      if (bellek_istek_o && bellek_istek_hazir_i) begin
        rq.push_back(mem(bellek_adres_o));
        acc.push_back(bellek_adres_o);
      end
      if (rq.size() > 0) begin nxt_v = 1; nxt_d = rq.pop_front(); end
      else nxt_v = 0;

      if (!m_busy) begin
        if (getir_istek_i) begin
          if (e_hit) m_hits++;
          else begin
            m_busy = 1; m_commit = 0; m_sent = 0; m_recv = 0;
            m_poison = temizle_i;
            m_line = {getir_ps_i[31:4], 4'h0};
            m_miss++;
          end
        end
        if (temizle_i) foreach (m_valid[i]) m_valid[i] = 1'b0;
      end else if (!m_commit) begin
        if (e_req && bellek_istek_hazir_i) m_sent++;
        if (bellek_yanit_gecerli_i) begin
          m_recv++;
          if (m_recv == 4) m_commit = 1;
        end
        if (temizle_i) begin
          m_poison = 1;
          foreach (m_valid[i]) m_valid[i] = 1'b0;
        end
      end else begin
        if (!m_poison && !temizle_i) begin
          m_valid[m_line[9:4]] = 1'b1;
          m_tag[m_line[9:4]]   = m_line[31:10];
        end
        if (temizle_i) foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_busy = 0; m_commit = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    bellek_yanit_gecerli_i = nxt_v;
    bellek_yanit_veri_i    = nxt_v ? nxt_d : 32'h0;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  task automatic wait_refill();
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (!m_busy) return;
    end
    tests++; fails++;
    $display("FAIL refill_timeout: refill still open after 40 cycles, required done");
  endtask

  task automatic chk_line(input string name, input logic [31:0] base);
    chk({name, "_count"}, 32'(acc.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk(name, (i < acc.size()) ? acc[i] : 32'hDEAD_DEAD, base + 32'(4 * i));
  endtask

  initial begin
    logic [31:0] exp_m;
    repeat (2) cyc();
    rst_i = 1'b0;
    look();
    chk("rst_gecerli", 32'(getir_gecerli_o), 32'd0);
    chk("rst_bekle", 32'(getir_bekle_o), 32'd0);
    chk("rst_istek", 32'(bellek_istek_o), 32'd0);
    chk("rst_adres", bellek_adres_o, 32'd0);
    chk("rst_buyruk", getir_buyruk_o, 32'd0);
    chk("rst_isabet", isabet_sayisi_o, 32'd0);
    chk("rst_iska", iska_sayisi_o, 32'd0);

    // cold miss on 0x100
    cyc(); acc.delete(); getir_istek_i = 1'b1; getir_ps_i = 32'h100;
    look();
    chk("cold_bekle", 32'(getir_bekle_o), 32'd1);
    chk("cold_gecerli", 32'(getir_gecerli_o), 32'd0);
    wait_refill(); look();
    chk("cold_hit", 32'(getir_gecerli_o), 32'd1);
    chk("cold_word", getir_buyruk_o, 32'hA0);
    chk("cold_nobekle", 32'(getir_bekle_o), 32'd0);
    chk_line("cold_req", 32'h100);

    // same-line hits
    cyc(); getir_ps_i = 32'h104; look();
    chk("hit104", getir_buyruk_o, 32'hA1);
    chk("hit104_bekle", 32'(getir_bekle_o), 32'd0);
    cyc(); getir_ps_i = 32'h10C; look();
    chk("hit10c", getir_buyruk_o, 32'hA3);
    chk("model_miss1", 32'(m_miss), 32'd1);
`ifdef ONBELLEK_SAYAC_EN
    exp_m = 32'd1;
`else
    exp_m = 32'd0;
`endif
    chk("iska_after_hits", iska_sayisi_o, exp_m);

    // conflict eviction: 0x500 shares the index of 0x100
    cyc(); getir_ps_i = 32'h500; look();
    chk("evict_bekle", 32'(getir_bekle_o), 32'd1);
    wait_refill(); look();
    chk("evict_word", getir_buyruk_o, 32'h1A0);

    // 0x100 misses again; second request held off for 3 cycles
    cyc(); acc.delete(); getir_ps_i = 32'h100; look();
    chk("remiss_bekle", 32'(getir_bekle_o), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      bellek_istek_hazir_i = !(k >= 2 && k <= 4);
      look();
      if (k >= 2 && k <= 4) begin
        chk("bp_adres", bellek_adres_o, 32'h104);
        chk("bp_istek", 32'(bellek_istek_o), 32'd1);
      end
    end
    bellek_istek_hazir_i = 1'b1;
    wait_refill(); look();
    chk("bp_word", getir_buyruk_o, 32'hA0);
    chk_line("bp_req", 32'h100);
    chk("model_miss3", 32'(m_miss), 32'd3);
`ifdef ONBELLEK_SAYAC_EN
    exp_m = 32'd3;
`else
    exp_m = 32'd0;
`endif
    chk("iska_after_evict", iska_sayisi_o, exp_m);
    cyc(); getir_ps_i = 32'h108; look();
    chk("bp_hit108", getir_buyruk_o, 32'hA2);

    // flush in the middle of a refill
    cyc(); getir_ps_i = 32'h200; look();
    chk("fl_bekle", 32'(getir_bekle_o), 32'd1);
    cyc(); cyc(); temizle_i = 1'b1;
    cyc(); temizle_i = 1'b0;
    wait_refill(); look();
    chk("fl_remiss", 32'(getir_gecerli_o), 32'd0);
    chk("fl_remiss_bekle", 32'(getir_bekle_o), 32'd1);
    wait_refill(); look();
    chk("fl_word", getir_buyruk_o, 32'hE0);
    cyc(); getir_ps_i = 32'h100; look();
    chk("fl_old_gone", 32'(getir_gecerli_o), 32'd0);
    wait_refill();

    // reset after two responses of a refill
    cyc(); getir_ps_i = 32'h300; look();
    chk("rr_bekle", 32'(getir_bekle_o), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (m_recv >= 2) break;
    end
    rst_i = 1'b1; getir_istek_i = 1'b0;
    cyc(); rst_i = 1'b0; look();
    chk("rr_istek", 32'(bellek_istek_o), 32'd0);
    chk("rr_bekle0", 32'(getir_bekle_o), 32'd0);
    cyc(); acc.delete(); getir_istek_i = 1'b1; look();
    chk("rr_remiss", 32'(getir_bekle_o), 32'd1);
    wait_refill(); look();
    chk("rr_word", getir_buyruk_o, 32'h120);
    chk_line("rr_req", 32'h300);

    cyc(); getir_istek_i = 1'b0;
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

endmodule

// File: doc/buyruk_onbellegi.md
Name: buyruk_onbellegi

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the fetch stage.
- Serves fetch's PC lookup in the same cycle on a hit.
- On a miss, stalls fetch and refills one line from main memory, one word per request, over a request/response handshake.
- Supports a full invalidate for fence.i.

Parameters:
- SATIR_SAYISI, 64: number of cache lines; power of two, ≥2.
- BLOK_KELIME, 4: 32-bit words per line; power of two, ≥2.
- BASLANGIC_TEMIZ, 1: if 1, all valid bits are cleared on reset (always used in this design).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- getir_istek_i  in  1  fetch presents a valid PC this cycle
- getir_ps_i  in  32  fetch PC (byte address, [1:0] ignored)
- getir_gecerli_o  out  1  getir_buyruk_o is valid for getir_ps_i this cycle
- getir_buyruk_o  out  32  instruction word
- getir_bekle_o  out  1  fetch must hold its PC (miss or refill in progress)
- temizle_i  in  1  invalidate the whole cache (fence.i)
- bellek_istek_o  out  1  memory read request valid
- bellek_adres_o  out  32  word-aligned request address
- bellek_istek_hazir_i  in  1  memory accepts the request this cycle
- bellek_yanit_gecerli_i  in  1  read data valid; responses arrive in request order
- bellek_yanit_veri_i  in  32  read data
- isabet_sayisi_o  out  32  hit counter (see Optional Feature)
- iska_sayisi_o  out  32  miss counter (see Optional Feature)

Behaviour:
- Address split, with OB = log2(BLOK_KELIME) and IB = log2(SATIR_SAYISI):
  - word offset = ps[OB+1:2]
  - index = ps[OB+IB+1:OB+2]
  - tag = ps[31:OB+IB+2]
- Storage: tag, valid and data arrays are flop/LUT-based with combinational read; writes are clocked.
- Hit: state BOSTA, getir_istek_i=1, valid[index]=1 and tag matches.
  - getir_gecerli_o=1, getir_buyruk_o = data[index][offset], getir_bekle_o=0, all in the same cycle (0-cycle latency).
- Miss: state BOSTA, getir_istek_i=1, no hit.
  - getir_gecerli_o=0, getir_bekle_o=1.
  - Next cycle the state is DOLDUR; the miss line address (ps with offset and [1:0] zeroed) and the tag are latched.
- getir_istek_i=0: getir_gecerli_o=0, getir_bekle_o=0, no state change.
- FSM states:
  - BOSTA → DOLDUR on a miss.
  - DOLDUR: keep issuing requests while the request counter < BLOK_KELIME. bellek_adres_o = line base + 4*request counter. The request counter increments on bellek_istek_o && bellek_istek_hazir_i.
  - Each bellek_yanit_gecerli_i writes data[index][response counter] and increments the response counter.
  - When the last response is written → YAZ.
  - YAZ: one cycle; write the tag, set valid[index]=1 (unless the refill was poisoned), → BOSTA. The fetch PC is re-looked-up in BOSTA and hits.
- In DOLDUR and YAZ: getir_gecerli_o=0, getir_bekle_o=1.
- A change of getir_ps_i during a refill (redirect) does not abort the refill. The line completes, then the new PC is looked up.
- bellek_istek_o=0 outside DOLDUR, and also in DOLDUR once all BLOK_KELIME requests are accepted.
- Requests hold address stable until accepted.
- temizle_i:
  - In BOSTA: clear all valid bits at the clock edge. The lookup in that same cycle still uses the old valid bits.
  - In DOLDUR/YAZ: set a poison flag. The refill still drains all responses; YAZ does not set valid. All valid bits are cleared immediately.
  - temizle_i together with a miss in BOSTA: the clear wins for the array, and the refill proceeds with the poison flag set.
- Reset: state=BOSTA, counters=0, all valid=0, poison=0. Outputs: bellek_istek_o=0, bellek_adres_o=0, getir_gecerli_o=0, getir_bekle_o=0, getir_buyruk_o=0 when not hitting, counters=0.
  - Reset mid-refill abandons the refill. Memory is reset on the same rst_i, so no stale responses arrive.
- Wrap-around: the request and response counters are OB+1 bits; the refill is complete at count == BLOK_KELIME.

Optional Feature:
- Macro: ONBELLEK_SAYAC_EN.
- Defined:
  - isabet_sayisi_o increments by 1 per hit cycle (BOSTA, getir_istek_i, hit).
  - iska_sayisi_o increments by 1 per BOSTA→DOLDUR transition.
  - Both counters are 32-bit wrapping, cleared on rst_i, and not cleared by temizle_i.
- Not defined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- Cold miss: after reset, getir_istek_i=1, ps=0x0000_0100, memory returns 0xA0,0xA1,0xA2,0xA3 with 1-cycle accept → requests to 0x100,0x104,0x108,0x10C; getir_bekle_o=1 until YAZ; the next BOSTA cycle gives getir_gecerli_o=1, getir_buyruk_o=0xA0.
- Same-line hits: ps=0x104, then 0x10C → 0xA1, then 0xA3, each with 0-cycle latency and getir_bekle_o=0; the miss counter stays 1.
- Conflict eviction: ps=0x500 (same index as 0x100 for 64x16B lines, different tag) → refill; then ps=0x100 misses again; iska_sayisi_o=3 with ONBELLEK_SAYAC_EN.
- Backpressure: bellek_istek_hazir_i low for 3 cycles on the 2nd request → bellek_adres_o holds 0x104 stable; the refill still fills words in order.
- Flush during refill: temizle_i pulsed mid-DOLDUR for ps=0x200 → all 4 responses consumed; after YAZ, ps=0x200 misses again.
- Reset mid-refill: rst_i after 2 responses → state BOSTA, bellek_istek_o=0; re-request of the same ps misses and refills all 4 words.
